// File: rtl/cnt_pkg.sv
// Shared constants for the up/down counter slice.
package cnt_pkg;
  localparam logic CNT_MODE_WRAP = 1'b0;
  localparam logic CNT_MODE_SAT  = 1'b1;
  localparam logic CNT_DIR_DOWN  = 1'b0;
  localparam logic CNT_DIR_UP    = 1'b1;
endpackage

// File: rtl/cnt_updown_mod_if.sv
// Control/status bundle of the up/down counter.
// Carries presc only when CNT_PRESCALE_EN is defined.
interface cnt_updown_mod_if #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] data_load;
  logic             en;
  logic             dir;
  logic             mode;
  logic [WIDTH-1:0] max_val;
  logic             ovf_clr;
`ifdef CNT_PRESCALE_EN
  logic [PRESC_W-1:0] presc;
`endif
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             at_max;
  logic             at_zero;
  logic             ovf;

  modport master (
`ifdef CNT_PRESCALE_EN
    output presc,
`endif
    output clr, load, data_load, en,
    output dir, mode, max_val, ovf_clr,
    input  cnt, tc, at_max, at_zero, ovf
  );

  modport slave (
`ifdef CNT_PRESCALE_EN
    input  presc,
`endif
    input  clr, load, data_load, en,
    input  dir, mode, max_val, ovf_clr,
    output cnt, tc, at_max, at_zero, ovf
  );
endinterface

// File: rtl/cnt_prescaler.sv
// Enable prescaler: ticks on every (presc+1)-th enabled cycle.
// A pc already past presc fires on the next enabled cycle.
module cnt_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);
  logic [PRESC_W-1:0] pc;
  logic               hit;

  assign hit  = (pc >= presc);
  assign tick = en && hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (en) begin
      pc <= hit ? '0 : pc + 1'b1;
    end
  end
endmodule

// File: rtl/cnt_updown_mod.sv
// Up/down counter with load, modulus, wrap/saturate and sticky ovf.
// Optional prescaler on en when CNT_PRESCALE_EN is defined.
module cnt_updown_mod
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input logic             clk,
  input logic             rst,
  cnt_updown_mod_if.slave bus
);
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             step;

`ifdef CNT_PRESCALE_EN
  cnt_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr | bus.load),
    .en    (bus.en),
    .presc (bus.presc),
    .tick  (step)
  );
`else
  assign step = bus.en;
`endif

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.load) begin
      cnt_d = (bus.data_load > bus.max_val) ?
              bus.max_val : bus.data_load;
    end else if (step) begin
      if (bus.dir == CNT_DIR_UP) begin
        if (cnt_q >= bus.max_val) begin
          tc_d  = 1'b1;
          cnt_d = (bus.mode == CNT_MODE_SAT) ?
                  bus.max_val : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          tc_d  = 1'b1;
          cnt_d = (bus.mode == CNT_MODE_SAT) ?
                  '0 : bus.max_val;
        // max_val dropped below cnt: pull back in range
        end else if (cnt_q > bus.max_val) begin
          cnt_d = bus.max_val;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      if (tc_d)
        ovf_q <= 1'b1;
      else if (bus.ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.tc      = tc_q;
  assign bus.ovf     = ovf_q;
  assign bus.at_max  = (cnt_q == bus.max_val);
  assign bus.at_zero = (cnt_q == '0);
endmodule

// File: tb/tb_cnt_updown_mod.sv
// Directed bench for cnt_updown_mod.
// Prescaler steps run only when CNT_PRESCALE_EN is defined.
module tb_cnt_updown_mod;
  localparam int WIDTH   = 16;
  localparam int PRESC_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  cnt_updown_mod_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

  cnt_updown_mod #(
    .WIDTH   (WIDTH),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int seq_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int seq_dn [4]  = '{1, 0, 0, 0};
  int tc_dn  [4]  = '{0, 0, 1, 1};
`ifdef CNT_PRESCALE_EN
  int seq_p  [8]  = '{0, 0, 0, 1, 1, 1, 1, 2};
`endif

  initial begin
    bus.clr = 0; bus.load = 0; bus.data_load = '0;
    bus.en = 0; bus.dir = 1; bus.mode = 0;
    bus.max_val = 16'd9; bus.ovf_clr = 0;
`ifdef CNT_PRESCALE_EN
    bus.presc = '0;
`endif
    tick(); tick();
    chk("rst_cnt", bus.cnt, 0);
    chk("rst_tc", bus.tc, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_zero", bus.at_zero, 1);
    rst = 0;
    tick();

    // wrap up 0..9
    bus.en = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("wrap_cnt%0d", i), bus.cnt, seq_up[i]);
      chk($sformatf("wrap_tc%0d", i), bus.tc, (i == 9));
      chk($sformatf("wrap_ovf%0d", i), bus.ovf, (i >= 9));
      chk($sformatf("wrap_max%0d", i), bus.at_max, (i == 8));
    end
    bus.en = 0;

    // async reset mid-count
    bus.load = 1; bus.data_load = 16'd5;
    tick();
    bus.load = 0;
    chk("pre_rst_cnt", bus.cnt, 5);
    chk("pre_rst_ovf", bus.ovf, 1);
    #3 rst = 1;
    #1;
    chk("arst_cnt", bus.cnt, 0);
    chk("arst_tc", bus.tc, 0);
    chk("arst_ovf", bus.ovf, 0);
    chk("arst_zero", bus.at_zero, 1);
    rst = 0;
    tick();

    // saturate down from 2
    bus.mode = 1; bus.dir = 0;
    bus.load = 1; bus.data_load = 16'd2;
    tick();
    bus.load = 0;
    chk("sat_load", bus.cnt, 2);
    bus.en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("sat_cnt%0d", i), bus.cnt, seq_dn[i]);
      chk($sformatf("sat_tc%0d", i), bus.tc, tc_dn[i]);
    end
    bus.en = 0;
    tick();
    chk("sat_tc_idle", bus.tc, 0);

    // priority and clamp
    bus.mode = 0; bus.max_val = 16'd100;
    bus.load = 1; bus.data_load = 16'd7;
    tick();
    chk("pri_pre", bus.cnt, 7);
    bus.clr = 1; bus.en = 1; bus.dir = 1;
    bus.data_load = 16'd50;
    tick();
    chk("pri_clr", bus.cnt, 0);
    chk("pri_tc", bus.tc, 0);
    bus.clr = 0; bus.en = 0;
    bus.data_load = 16'd500;
    tick();
    bus.load = 0;
    chk("clamp", bus.cnt, 100);
    chk("clamp_max", bus.at_max, 1);
    bus.max_val = 16'd50; bus.dir = 0; bus.en = 1;
    tick();
    bus.en = 0;
    chk("lower_cnt", bus.cnt, 50);
    chk("lower_tc", bus.tc, 0);

    // ovf clear vs set
    bus.ovf_clr = 1;
    tick();
    chk("ovfclr", bus.ovf, 0);
    bus.ovf_clr = 0;
    bus.max_val = 16'd3; bus.dir = 1;
    bus.load = 1; bus.data_load = 16'd3;
    tick();
    bus.load = 0;
    bus.en = 1; bus.ovf_clr = 1;
    tick();
    chk("ovf_same_cnt", bus.cnt, 0);
    chk("ovf_same_tc", bus.tc, 1);
    chk("ovf_same", bus.ovf, 1);
    bus.en = 0;
    tick();
    chk("ovf_next", bus.ovf, 0);
    chk("ovf_next_tc", bus.tc, 0);
    bus.ovf_clr = 0;

`ifdef CNT_PRESCALE_EN
    bus.max_val = 16'd100; bus.dir = 1; bus.mode = 0;
    bus.presc = 8'd3; bus.clr = 1;
    tick();
    bus.clr = 0; bus.en = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("psc_cnt%0d", i), bus.cnt, seq_p[i]);
    end
    tick(); tick();
    chk("psc_mid", bus.cnt, 2);
    bus.load = 1; bus.data_load = 16'd10;
    tick();
    bus.load = 0;
    chk("psc_load", bus.cnt, 10);
    tick(); tick(); tick();
    chk("psc_hold", bus.cnt, 10);
    tick();
    chk("psc_step", bus.cnt, 11);
    bus.presc = 8'd0;
    tick();
    chk("psc0_a", bus.cnt, 12);
    tick();
    chk("psc0_b", bus.cnt, 13);
    bus.en = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
